// File: rtl/port_tx_queue_pkg.sv
// Shared types and helpers for the buffered serial transmit port.
package port_tx_queue_pkg;

    // Serializer states; PARITY is only visited when parity is enabled.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Ceiling log2 usable in port and localparam widths (returns 0 for 1).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/port_tx_queue_sync_fifo.sv
// Synchronous FIFO with registered flags and registered read data.
// Read data appears on dout the cycle after r is accepted (no fall-through).
module sync_fifo
    import port_tx_queue_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w,
    input  logic                  r,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  is_full,
    output logic                  is_empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              full_q, empty_q, overflow_q;
    logic              wr_en, rd_en;

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    assign wr_en = w && !full_q;
    assign rd_en = r && !empty_q;

    // Occupancy bookkeeping; simultaneous accept and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage array and registered read port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
        if (rd_en) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    // Pointers, count and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= w && full_q;
        end
    end

    assign dout     = dout_q;
    assign is_full  = full_q;
    assign is_empty = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/port_tx_queue.sv
// Buffered UART transmitter: write-side FIFO drained autonomously by a
// serializer. Frames are start, DATA_W bits LSB first, optional parity, stop.
module port_tx_queue
    import port_tx_queue_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w,
    input  logic [DATA_W-1:0]     din,
    output logic                  is_full,
    output logic                  is_empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .w        (w),
        .r        (fifo_rd),
        .din      (din),
        .dout     (fifo_dout),
        .is_full  (is_full),
        .is_empty (fifo_empty),
        .count    (count),
        .overflow (overflow)
    );

    assign is_empty = fifo_empty;

    // Serializer next state; tx_d is the line level for the following cycle
    // so the pin is driven straight from a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fifo_rd  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d  = fifo_dout;
                parity_d = (^fifo_dout) ^ PAR_ODD;
                baud_d   = '0;
                tx_d     = 1'b0;
                state_d  = ST_START;
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                // Registered pulse lands on the final stop-bit cycle.
                if (baud_q == BAUD_PRE) begin
                    done_d = 1'b1;
                end
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serializer registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
